// File: rtl/mult_seq_ctrl.sv
// Sequencer for a shift-add unsigned multiplier driving an external
// enable-loaded accumulator register and reporting a registered product.
module mult_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [ACC_W-1:0]   acc_q,
    output logic               acc_en,
    output logic [ACC_W-1:0]   acc_d,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH-1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;

    assign busy = (state != IDLE);

    // State, operand latches, iteration index and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            done    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= next;
            done  <= (state == DONE);
            if (state == IDLE && start) begin
                a_lat <= a;
                b_lat <= b;
                idx   <= '0;
            end
            if (state == RUN)
                idx <= idx + 1'b1;
            if (state == DONE) begin
                product <= acc_q[2*WIDTH-1:0];
                ovf     <= acc_q[ACC_W-1];
            end
        end
    end

    // Next state and accumulator enable/data for the current step
    always_comb begin
        next   = state;
        acc_en = 1'b0;
        acc_d  = '0;
        unique case (state)
            IDLE: begin
                if (start)
                    next = CLEAR;
            end
            CLEAR: begin
                acc_en = 1'b1;
                next   = RUN;
            end
            RUN: begin
                if (b_lat[idx]) begin
                    acc_en = 1'b1;
                    acc_d  = acc_q + (ACC_W'(a_lat) << idx);
                end
                if (idx == LAST)
                    next = DONE;
            end
            DONE: begin
                next = IDLE;
            end
        endcase
        if (reset) begin
            acc_en = 1'b0;
            acc_d  = '0;
        end
    end

endmodule
